// File: rtl/instr_mem_pipe.sv
// rtl/instr_mem_pipe.sv - pipelined instruction memory with fault tagging, stall and flush
//
// Ports:
//   CLK        single clock, rising edge
//   resetl     asynchronous active-low reset
//   req_valid  fetch request present
//   req_ready  request accepted when req_valid && req_ready at an edge
//   req_addr   byte address of the fetch (64 bits)
//   flush      discard every in-flight fetch (branch redirect)
//   rsp_valid  response present
//   rsp_ready  consumer takes the response
//   rsp_data   instruction word (FAULT_WORD on a faulting fetch)
//   rsp_addr   echo of the request address
//   rsp_fault  fetch was misaligned or out of range
//   wr_en      program-load write strobe
//   wr_addr    byte address of the load
//   wr_data    word to load
module instr_mem_pipe #(
   parameter int          DEPTH      = 64,
   parameter int          RD_LAT     = 2,
   parameter logic [31:0] FAULT_WORD = 32'h00000000
) (
   input  logic        CLK,
   input  logic        resetl,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic [63:0] req_addr,
   input  logic        flush,
   output logic        rsp_valid,
   input  logic        rsp_ready,
   output logic [31:0] rsp_data,
   output logic [63:0] rsp_addr,
   output logic        rsp_fault,
   input  logic        wr_en,
   input  logic [63:0] wr_addr,
   input  logic [31:0] wr_data
);

   localparam int AW = $clog2(DEPTH);

   logic [31:0] mem [DEPTH];

   logic        st_v    [RD_LAT];
   logic [31:0] st_data [RD_LAT];
   logic [63:0] st_addr [RD_LAT];
   logic        st_f    [RD_LAT];

   logic          stall;
   logic          accept;
   logic          rd_fault;
   logic          wr_fault;
   logic [AW-1:0] rd_idx;
   logic [AW-1:0] wr_idx;

   // Fault when misaligned or when any word-index bit above the array size is set.
   assign rd_fault = (req_addr[1:0] != 2'b00) || (|req_addr[63:AW+2]);
   assign wr_fault = (wr_addr[1:0]  != 2'b00) || (|wr_addr[63:AW+2]);
   assign rd_idx   = req_addr[AW+1:2];
   assign wr_idx   = wr_addr[AW+1:2];

   assign stall     = st_v[RD_LAT-1] && !rsp_ready;
   assign req_ready = !stall && !wr_en && !flush;
   assign accept    = req_valid && req_ready;

   assign rsp_valid = st_v[RD_LAT-1];
   assign rsp_data  = st_data[RD_LAT-1];
   assign rsp_addr  = st_addr[RD_LAT-1];
   assign rsp_fault = st_f[RD_LAT-1];

   // Program-load port; array is deliberately left out of reset.
   always_ff @(posedge CLK) begin
      if (wr_en && !wr_fault) begin
         mem[wr_idx] <= wr_data;
      end
   end

   // Stage 0 captures the word at acceptance, so later writes cannot alter
   // a fetch already in flight. Flush wins over stall.
   always_ff @(posedge CLK or negedge resetl) begin
      if (!resetl) begin
         for (int i = 0; i < RD_LAT; i++) begin
            st_v[i]    <= 1'b0;
            st_data[i] <= 32'h0;
            st_addr[i] <= 64'h0;
            st_f[i]    <= 1'b0;
         end
      end else if (flush) begin
         for (int i = 0; i < RD_LAT; i++) begin
            st_v[i] <= 1'b0;
         end
      end else if (!stall) begin
         st_v[0] <= accept;
         if (accept) begin
            st_data[0] <= rd_fault ? FAULT_WORD : mem[rd_idx];
            st_addr[0] <= req_addr;
            st_f[0]    <= rd_fault;
         end
         for (int i = 1; i < RD_LAT; i++) begin
            st_v[i]    <= st_v[i-1];
            st_data[i] <= st_data[i-1];
            st_addr[i] <= st_addr[i-1];
            st_f[i]    <= st_f[i-1];
         end
      end
   end

endmodule

// File: tb/tb_instr_mem_pipe.sv
// tb/tb_instr_mem_pipe.sv - scoreboard bench for instr_mem_pipe (DEPTH=64, RD_LAT=2)
module tb_instr_mem_pipe;

   logic        CLK;
   logic        resetl;
   logic        req_valid;
   logic        req_ready;
   logic [63:0] req_addr;
   logic        flush;
   logic        rsp_valid;
   logic        rsp_ready;
   logic [31:0] rsp_data;
   logic [63:0] rsp_addr;
   logic        rsp_fault;
   logic        wr_en;
   logic [63:0] wr_addr;
   logic [31:0] wr_data;

   instr_mem_pipe #(.DEPTH(64), .RD_LAT(2), .FAULT_WORD(32'h00000000)) dut (
      .CLK(CLK), .resetl(resetl),
      .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
      .flush(flush),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
      .rsp_addr(rsp_addr), .rsp_fault(rsp_fault),
      .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data)
   );

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   typedef struct {
      logic [31:0] d;
      logic [63:0] a;
      logic        f;
   } exp_t;

   exp_t        sbq [$];
   logic [31:0] model_mem [64];
   int          checks = 0;
   int          errors = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   function automatic logic is_fault(input logic [63:0] a);
      return (a[1:0] != 2'b00) || (a[63:2] >= 62'd64);
   endfunction

   function automatic exp_t model_read(input logic [63:0] a);
      exp_t e;
      e.a = a;
      e.f = is_fault(a);
      e.d = e.f ? 32'h0 : model_mem[a[7:2]];
      return e;
   endfunction

   function automatic void model_write(input logic [63:0] a, input logic [31:0] d);
      if (!is_fault(a)) model_mem[a[7:2]] = d;
   endfunction

   // Monitor: pops expected entries whenever a response transfer will occur at the next edge.
   logic        prev_stall = 1'b0;
   logic [31:0] prev_d;
   logic [63:0] prev_a;
   logic        prev_f;

   always @(negedge CLK) begin
      if (resetl) begin
         if (prev_stall) begin
            check("stall_hold_valid", rsp_valid, 1'b1);
            check("stall_hold_data", rsp_data, prev_d);
            check("stall_hold_addr", rsp_addr, prev_a);
            check("stall_hold_fault", rsp_fault, prev_f);
         end
         check("req_ready_rule", req_ready, !(rsp_valid && !rsp_ready) && !wr_en && !flush);
         if (rsp_valid && rsp_ready && !flush) begin
            if (sbq.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL unexpected_rsp: got addr %h data %h with nothing outstanding", rsp_addr, rsp_data);
            end else begin
               exp_t e;
               e = sbq.pop_front();
               check("rsp_data", rsp_data, e.d);
               check("rsp_addr", rsp_addr, e.a);
               check("rsp_fault", rsp_fault, e.f);
            end
         end
         prev_stall = rsp_valid && !rsp_ready && !flush;
         prev_d = rsp_data;
         prev_a = rsp_addr;
         prev_f = rsp_fault;
      end else begin
         prev_stall = 1'b0;
      end
   end

   // One cycle of stimulus: bookkeeping at the negedge, inputs change 1 after the posedge.
   task automatic cyc(output bit acc);
      @(negedge CLK);
      acc = resetl && req_valid && req_ready;
      if (resetl) begin
         if (flush) sbq.delete();
         else if (acc) sbq.push_back(model_read(req_addr));
         if (wr_en) model_write(wr_addr, wr_data);
      end
      @(posedge CLK);
      #1;
   endtask

   task automatic idle(input int n);
      bit acc;
      for (int i = 0; i < n; i++) cyc(acc);
   endtask

   task automatic do_write(input logic [63:0] a, input logic [31:0] d);
      bit acc;
      wr_en = 1'b1;
      wr_addr = a;
      wr_data = d;
      cyc(acc);
      wr_en = 1'b0;
   endtask

   task automatic do_req(input logic [63:0] a);
      bit acc;
      int n;
      req_valid = 1'b1;
      req_addr = a;
      acc = 1'b0;
      n = 0;
      while (!acc && n < 50) begin
         cyc(acc);
         n++;
      end
      req_valid = 1'b0;
      if (!acc) begin
         checks++;
         errors++;
         $display("FAIL req_timeout: addr %h not accepted within 50 cycles", a);
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
      $fatal(1, "watchdog");
   end

   initial begin
      bit acc;
      resetl = 1'b0;
      req_valid = 1'b0;
      req_addr = '0;
      flush = 1'b0;
      rsp_ready = 1'b1;
      wr_en = 1'b0;
      wr_addr = '0;
      wr_data = '0;
      #2;
      check("reset_rsp_valid", rsp_valid, 1'b0);
      check("reset_rsp_data", rsp_data, 32'h0);
      check("reset_rsp_addr", rsp_addr, 64'h0);
      check("reset_rsp_fault", rsp_fault, 1'b0);
      @(posedge CLK);
      @(posedge CLK);
      #1;
      resetl = 1'b1;
      #1;
      check("req_ready_after_reset", req_ready, 1'b1);

      // Program load: whole array gets known contents.
      for (int i = 0; i < 64; i++) begin
         logic [31:0] w;
         w = (i == 0) ? 32'hF84003E9 : (i == 1) ? 32'hF84083EA : $urandom;
         do_write(64'(i * 4), w);
      end

      // Basic fetch and latency.
      do_req(64'h0);
      check("lat_not_early", rsp_valid, 1'b0);
      cyc(acc);
      check("lat_visible", rsp_valid, 1'b1);
      check("basic_data", rsp_data, 32'hF84003E9);
      check("basic_addr", rsp_addr, 64'h0);
      idle(3);

      // Streaming: three back-to-back accepts, three consecutive responses.
      req_valid = 1'b1;
      req_addr = 64'h0;
      cyc(acc);
      check("stream_acc0", acc, 1'b1);
      req_addr = 64'h4;
      cyc(acc);
      check("stream_acc1", acc, 1'b1);
      check("stream_rsp0", rsp_valid, 1'b1);
      req_addr = 64'h8;
      cyc(acc);
      check("stream_acc2", acc, 1'b1);
      check("stream_rsp1", rsp_valid, 1'b1);
      req_valid = 1'b0;
      cyc(acc);
      check("stream_rsp2", rsp_valid, 1'b1);
      cyc(acc);
      check("stream_done", rsp_valid, 1'b0);
      idle(2);

      // Stall with two in flight.
      rsp_ready = 1'b0;
      do_req(64'h0);
      do_req(64'h4);
      for (int i = 0; i < 3; i++) begin
         check("stall_req_ready", req_ready, 1'b0);
         check("stall_data", rsp_data, 32'hF84003E9);
         cyc(acc);
      end
      rsp_ready = 1'b1;
      idle(4);

      // Faults.
      do_req(64'h2);
      do_req(64'h100);
      idle(3);
      do_write(64'h100, 32'hDEADBEEF);
      do_req(64'h0);
      idle(3);

      // Flush without stall.
      do_req(64'h8);
      do_req(64'hC);
      flush = 1'b1;
      cyc(acc);
      flush = 1'b0;
      check("flush_clear", rsp_valid, 1'b0);
      do_req(64'h4);
      idle(3);

      // Flush during stall.
      rsp_ready = 1'b0;
      do_req(64'h8);
      do_req(64'hC);
      cyc(acc);
      flush = 1'b1;
      cyc(acc);
      flush = 1'b0;
      check("flush_stall_clear", rsp_valid, 1'b0);
      rsp_ready = 1'b1;
      do_req(64'h4);
      idle(3);

      // Write after read: in-flight read keeps the old word.
      do_req(64'h0);
      do_write(64'h0, 32'h8B0901AD);
      do_req(64'h0);
      idle(3);

      // Reset mid-stream.
      do_req(64'h4);
      do_req(64'h8);
      resetl = 1'b0;
      sbq.delete();
      #1;
      check("midreset_valid", rsp_valid, 1'b0);
      check("midreset_data", rsp_data, 32'h0);
      check("midreset_addr", rsp_addr, 64'h0);
      check("midreset_fault", rsp_fault, 1'b0);
      @(posedge CLK);
      @(posedge CLK);
      #1;
      resetl = 1'b1;
      #1;
      check("req_ready_after_midreset", req_ready, 1'b1);
      idle(4);
      do_req(64'h4);
      idle(3);

      // Randomized traffic.
      for (int n = 0; n < 400; n++) begin
         int sel;
         req_valid = ($urandom_range(0, 9) < 7);
         sel = $urandom_range(0, 9);
         if (sel < 8) req_addr = 64'($urandom_range(0, 63) * 4);
         else if (sel == 8) req_addr = 64'($urandom_range(0, 63) * 4 + $urandom_range(1, 3));
         else req_addr = ($urandom_range(0, 1) != 0) ? {$urandom, $urandom} | 64'h100
                                                     : 64'($urandom_range(64, 200) * 4);
         rsp_ready = ($urandom_range(0, 3) != 0);
         wr_en = ($urandom_range(0, 9) == 0);
         wr_addr = ($urandom_range(0, 7) == 0) ? 64'($urandom_range(0, 300))
                                               : 64'($urandom_range(0, 63) * 4);
         wr_data = $urandom;
         flush = ($urandom_range(0, 29) == 0);
         cyc(acc);
      end
      req_valid = 1'b0;
      wr_en = 1'b0;
      flush = 1'b0;
      rsp_ready = 1'b1;
      idle(6);
      check("drain_empty", 64'(sbq.size()), 64'h0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
